// File: rtl/booth_mul_scheduler.sv
// booth_mul_scheduler: round-robin arbiter sharing one sequential signed Booth multiplier among NREQ requesters
module booth_mul_scheduler #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] a_in,
  input  logic [NREQ*8-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [15:0]       result,
  output logic              sched_busy,
  output logic              mul_start,
  output logic [7:0]        mul_mc,
  output logic [7:0]        mul_mp,
  input  logic              mul_busy,
  input  logic [15:0]       mul_prod
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, CAPTURE} state_t;
  state_t          r_state, w_next;
  logic [NREQ-1:0] r_gnt, r_done, w_elig;
  logic [15:0]     r_result;
  logic            r_busy, r_start, w_any, w_take;
  logic [7:0]      r_mc, r_mp;
  logic [IW-1:0]   r_idx, r_ptr, w_idx;
  int              w_j;
  // A requester whose done is pulsing this cycle is masked so it cannot win twice in a row
  assign w_elig = req & ~r_done;
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    w_j   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = int'(r_ptr) + k;
      w_j = (w_j >= NREQ) ? w_j - NREQ : w_j;
      if (w_elig[IW'(w_j)]) begin
        w_any = 1'b1;
        w_idx = IW'(w_j);
      end
    end
  end
  assign w_take = (r_state == IDLE) && w_any;
  // mul_busy is only consulted in RUN; the multiplier has no reset and may report X while idle
  always_comb begin
    w_next = (r_state == IDLE)   ? (w_any ? LAUNCH : IDLE) :
             (r_state == LAUNCH) ? RUN :
             (r_state == RUN)    ? (mul_busy ? RUN : CAPTURE) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt    <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_mc     <= '0;
      r_mp     <= '0;
      r_idx    <= '0;
      r_ptr    <= '0;
    end else begin
      r_start <= w_take;
      r_busy  <= (w_next != IDLE);
      r_done  <= (r_state == CAPTURE) ? NREQ'(1) << r_idx : '0;
      if (w_take) begin
        r_idx <= w_idx;
        r_mc  <= a_in[8*w_idx +: 8];
        r_mp  <= b_in[8*w_idx +: 8];
        r_gnt <= NREQ'(1) << w_idx;
      end
      if (r_state == CAPTURE) begin
        r_result <= mul_prod;
        r_gnt    <= '0;
        r_ptr    <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
      end
    end
  end
  assign gnt        = r_gnt;
  assign done       = r_done;
  assign result     = r_result;
  assign sched_busy = r_busy;
  assign mul_start  = r_start;
  assign mul_mc     = r_mc;
  assign mul_mp     = r_mp;
endmodule

// File: tb/tb_booth_mul_scheduler.sv
// tb_booth_mul_scheduler: scoreboard bench with a behavioural 9-cycle multiplier behind the scheduler
module tb_booth_mul_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_in, b_in;
  logic [3:0]  gnt, done;
  logic [15:0] result;
  logic        sched_busy, mul_start, mul_busy;
  logic [7:0]  mul_mc, mul_mp;
  logic [15:0] mul_prod;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int overlap = 0;

  typedef struct {
    logic [3:0]  d;
    logic [15:0] r;
    int          c;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;

  logic        m_busy = 1'b0;
  logic        force_busy = 1'b0;
  int          m_cnt = 0;
  logic [7:0]  m_a, m_b;
  logic [15:0] m_prod;

  booth_mul_scheduler #(.NREQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .sched_busy(sched_busy),
    .mul_start(mul_start), .mul_mc(mul_mc), .mul_mp(mul_mp),
    .mul_busy(mul_busy), .mul_prod(mul_prod)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: busy for 9 cycles after start, product valid once busy falls
  assign mul_busy = m_busy | force_busy;
  assign mul_prod = m_prod;
  always @(posedge clk) begin
    if (mul_start) begin
      if (m_busy) overlap <= overlap + 1;
      n_start <= n_start + 1;
      m_cnt   <= 9;
      m_busy  <= 1'b1;
      m_a     <= mul_mc;
      m_b     <= mul_mp;
      m_prod  <= 'x;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_prod <= 16'($signed(m_a) * $signed(m_b));
      end
    end
  end

  // Scoreboard: every done pulse must match the oldest expectation in value and cycle
  always @(negedge clk) begin
    if (!rst && done !== 4'b0000) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done done=%b result=%h cyc=%0d", done, result, cyc);
      end else begin
        m_e = sb.pop_front();
        if (done !== m_e.d || result !== m_e.r || cyc != m_e.c) begin
          errors++;
          $display("FAIL sb_done got done=%b result=%h cyc=%0d exp done=%b result=%h cyc=%0d",
                   done, result, cyc, m_e.d, m_e.r, m_e.c);
        end
      end
    end
  end

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (gnt !== 4'b0 || done !== 4'b0 || sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl gnt=%b done=%b busy=%b exp 0", gnt, done, sched_busy);
    end
    checks++;
    if (result !== 16'h0 || mul_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_data result=%h start=%b exp 0", result, mul_start);
    end
    checks++;
    if (mul_mc !== 8'h0 || mul_mp !== 8'h0) begin
      errors++;
      $display("FAIL reset_ops mc=%h mp=%h exp 0", mul_mc, mul_mp);
    end
  endtask

  task automatic test_single();
    int t0, s0;
    t0 = cyc;
    s0 = n_start;
    req = 4'b0001;
    a_in[7:0] = 8'd3;
    b_in[7:0] = 8'd5;
    sb.push_back('{4'b0001, 16'h000F, t0 + 13});
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL single_gnt_c0 got=%b exp=0000", gnt);
    end
    go_to(t0 + 1);
    req = 4'b0000;
    checks++;
    if (gnt !== 4'b0001 || mul_start !== 1'b1 || sched_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_c1 gnt=%b start=%b busy=%b exp 0001/1/1", gnt, mul_start, sched_busy);
    end
    go_to(t0 + 2);
    checks++;
    if (mul_start !== 1'b0) begin
      errors++;
      $display("FAIL single_start_c2 got=%b exp=0", mul_start);
    end
    go_to(t0 + 12);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL single_gnt_c12 got=%b exp=0001", gnt);
    end
    go_to(t0 + 13);
    checks++;
    if (gnt !== 4'b0000 || sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_c13 gnt=%b busy=%b exp 0000/0", gnt, sched_busy);
    end
    go_to(t0 + 14);
    checks++;
    if (sb.size() != 0 || n_start - s0 != 1) begin
      errors++;
      $display("FAIL single_end pending=%0d starts=%0d exp 0/1", sb.size(), n_start - s0);
    end
  endtask

  task automatic test_negative();
    int t0;
    t0 = cyc;
    req = 4'b0100;
    a_in[23:16] = 8'hF9;
    b_in[23:16] = 8'h06;
    sb.push_back('{4'b0100, 16'hFFD6, t0 + 13});
    go_to(t0 + 1);
    req = 4'b0000;
    go_to(t0 + 2);
    checks++;
    if (mul_mc !== 8'hF9 || mul_mp !== 8'h06 || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL neg_ops mc=%h mp=%h gnt=%b exp F9/06/0100", mul_mc, mul_mp, gnt);
    end
    go_to(t0 + 14);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL neg_end pending=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_round_robin();
    int t0, s0;
    rst = 1'b1;
    go_to(cyc + 2);
    rst = 1'b0;
    t0 = cyc;
    s0 = n_start;
    req = 4'b1111;
    a_in = {8'hFF, 8'h7F, 8'h80, 8'h02};
    b_in = {8'h05, 8'h80, 8'h80, 8'h03};
    sb.push_back('{4'b0001, 16'h0006, t0 + 13});
    sb.push_back('{4'b0010, 16'h4000, t0 + 26});
    sb.push_back('{4'b0100, 16'hC080, t0 + 39});
    sb.push_back('{4'b1000, 16'hFFFB, t0 + 52});
    go_to(t0 + 13);
    req[0] = 1'b0;
    go_to(t0 + 14);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rr_next_gnt got=%b exp=0010", gnt);
    end
    go_to(t0 + 26);
    req[1] = 1'b0;
    go_to(t0 + 39);
    req[2] = 1'b0;
    go_to(t0 + 52);
    req[3] = 1'b0;
    go_to(t0 + 53);
    checks++;
    if (sb.size() != 0 || n_start - s0 != 4 || overlap != 0) begin
      errors++;
      $display("FAIL rr_end pending=%0d starts=%0d overlap=%0d exp 0/4/0", sb.size(), n_start - s0, overlap);
    end
  endtask

  task automatic test_fairness();
    int t0;
    t0 = cyc;
    req = 4'b0001;
    a_in[7:0] = 8'd2;
    b_in[7:0] = 8'd7;
    sb.push_back('{4'b0001, 16'h000E, t0 + 13});
    sb.push_back('{4'b0010, 16'hFFEE, t0 + 26});
    sb.push_back('{4'b0001, 16'h0064, t0 + 39});
    sb.push_back('{4'b0010, 16'hFFEE, t0 + 52});
    go_to(t0 + 5);
    req[1] = 1'b1;
    a_in[15:8] = 8'hFE;
    b_in[15:8] = 8'd9;
    go_to(t0 + 20);
    a_in[7:0] = 8'd10;
    b_in[7:0] = 8'd10;
    go_to(t0 + 52);
    req = 4'b0000;
    go_to(t0 + 53);
    checks++;
    if (sb.size() != 0 || sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL fair_end pending=%0d busy=%b exp 0/0", sb.size(), sched_busy);
    end
  endtask

  task automatic test_drop_and_latch();
    int t0;
    t0 = cyc;
    req = 4'b1000;
    a_in[31:24] = 8'h0C;
    b_in[31:24] = 8'hFD;
    sb.push_back('{4'b1000, 16'hFFDC, t0 + 13});
    go_to(t0 + 3);
    req = 4'b0000;
    a_in[31:24] = 8'h55;
    b_in[31:24] = 8'h01;
    go_to(t0 + 4);
    checks++;
    if (mul_mc !== 8'h0C || mul_mp !== 8'hFD || gnt !== 4'b1000) begin
      errors++;
      $display("FAIL drop_latched mc=%h mp=%h gnt=%b exp 0C/FD/1000", mul_mc, mul_mp, gnt);
    end
    go_to(t0 + 14);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drop_end pending=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_stuck_busy();
    int t0, s0;
    t0 = cyc;
    s0 = n_start;
    force_busy = 1'b1;
    req = 4'b1000;
    a_in[31:24] = 8'h10;
    b_in[31:24] = 8'h10;
    go_to(t0 + 1);
    req = 4'b0000;
    go_to(t0 + 20);
    checks++;
    if (gnt !== 4'b1000 || sched_busy !== 1'b1 || mul_start !== 1'b0) begin
      errors++;
      $display("FAIL stuck_hold gnt=%b busy=%b start=%b exp 1000/1/0", gnt, sched_busy, mul_start);
    end
    checks++;
    if (n_start - s0 != 1) begin
      errors++;
      $display("FAIL stuck_starts got=%0d exp=1", n_start - s0);
    end
    go_to(t0 + 30);
    force_busy = 1'b0;
    sb.push_back('{4'b1000, 16'h0100, t0 + 32});
    go_to(t0 + 33);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stuck_end pending=%0d exp 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_op();
    int t0;
    t0 = cyc;
    req = 4'b0001;
    a_in[7:0] = 8'd7;
    b_in[7:0] = 8'd9;
    go_to(t0 + 1);
    req = 4'b0000;
    go_to(t0 + 7);
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0 || result !== 16'h0 || done !== 4'b0 || sched_busy !== 1'b0 || mul_mc !== 8'h0) begin
      errors++;
      $display("FAIL midrst gnt=%b result=%h done=%b busy=%b mc=%h exp all 0",
               gnt, result, done, sched_busy, mul_mc);
    end
    go_to(t0 + 9);
    rst = 1'b0;
    go_to(t0 + 12);
    req = 4'b0010;
    a_in[15:8] = 8'hFF;
    b_in[15:8] = 8'hFF;
    sb.push_back('{4'b0010, 16'h0001, t0 + 25});
    go_to(t0 + 13);
    req = 4'b0000;
    go_to(t0 + 26);
    checks++;
    if (sb.size() != 0 || result !== 16'h0001) begin
      errors++;
      $display("FAIL midrst_end pending=%0d result=%h exp 0/0001", sb.size(), result);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0;
    a_in = '0;
    b_in = '0;
    go_to(3);
    test_reset();
    rst = 1'b0;
    go_to(5);
    test_single();
    test_negative();
    test_round_robin();
    test_fairness();
    test_drop_and_latch();
    test_stuck_busy();
    test_reset_mid_op();
    go_to(cyc + 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d exp finish", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
